shift_seq_ctrl: RTL and testbench

Command-driven sequencer for an 8-stage × 16-bit word shift chain. It accepts one command at a time over a valid/ready handshake and sequences the chain through four operations: push a word, rotate N positions, clear, or no-op. It reports completion with a one-cycle `done` pulse. It sits between a control master (test sequencer or CPU-side register block) and the stage-chain datapath, and exposes every stage's contents plus an occupancy bit per stage.

---
 rtl/shift_seq_pkg.sv | 19 +
 rtl/shift_stage_chain.sv | 56 +++++
 rtl/shift_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings and defaults for the shift-chain sequencer.
package shift_seq_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 4;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_PUSH   = 2'd1;
  localparam logic [1:0] OP_ROTATE = 2'd2;
  localparam logic [1:0] OP_CLEAR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_stage_chain.sv
// DEPTH x WIDTH register chain with per-stage occupancy bits; stage 0 is the
// input end, a shift either loads din or recirculates the tap-end word.
module shift_stage_chain
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift_en,
  input  logic                   recirc,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH*DEPTH-1:0] stage_data,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [WIDTH-1:0]       tap_out
);

  logic [WIDTH*DEPTH-1:0] data_r;
  logic [DEPTH-1:0]       valid_r;
  logic [WIDTH-1:0]       head_s;
  logic                   head_valid_s;

  // Select what enters stage 0 on a shift.
  always_comb begin
    head_s       = din;
    head_valid_s = 1'b1;
    if (recirc) begin
      head_s       = data_r[WIDTH*(DEPTH-1) +: WIDTH];
      head_valid_s = valid_r[DEPTH-1];
    end else begin
      head_s       = din;
      head_valid_s = 1'b1;
    end
  end

  // Chain storage: clear wins over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= {(WIDTH*DEPTH){1'b0}};
      valid_r <= {DEPTH{1'b0}};
    end else if (clear) begin
      data_r  <= {(WIDTH*DEPTH){1'b0}};
      valid_r <= {DEPTH{1'b0}};
    end else if (shift_en) begin
      data_r  <= {data_r[WIDTH*(DEPTH-1)-1:0], head_s};
      valid_r <= {valid_r[DEPTH-2:0], head_valid_s};
    end
  end

  assign stage_data  = data_r;
  assign stage_valid = valid_r;
  assign tap_out     = data_r[WIDTH*(DEPTH-1) +: WIDTH];

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the stage chain: accepts one command at a time and
// drives push / rotate / clear steps, pulsing done on completion.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [CNT_W-1:0]       cmd_len,
  input  logic [WIDTH-1:0]       cmd_data,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       tap_out,
  output logic [WIDTH*DEPTH-1:0] stage_data,
  output logic [DEPTH-1:0]       stage_valid
);

  state_e           state_r;
  logic [CNT_W-1:0] rem_r;
  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic             shift_en_s;
  logic             recirc_s;
  logic             clear_s;

  assign accept_s = cmd_valid && ready_r;

  // Datapath strobes: push/clear act on the accept edge, rotates in SHIFT.
  always_comb begin
    shift_en_s = 1'b0;
    recirc_s   = 1'b0;
    clear_s    = 1'b0;
    if (state_r == ST_SHIFT) begin
      shift_en_s = 1'b1;
      recirc_s   = 1'b1;
    end else if (accept_s && (cmd_op == OP_PUSH)) begin
      shift_en_s = 1'b1;
    end else if (accept_s && (cmd_op == OP_CLEAR)) begin
      clear_s    = 1'b1;
    end else begin
      shift_en_s = 1'b0;
    end
  end

  // Sequencer FSM; handshake/status outputs are flops tracking the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      rem_r   <= {CNT_W{1'b0}};
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            ready_r <= 1'b0;
            if ((cmd_op == OP_ROTATE) && (cmd_len != {CNT_W{1'b0}})) begin
              state_r <= ST_SHIFT;
              rem_r   <= cmd_len;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (rem_r == CNT_W'(1)) begin
            state_r <= ST_DONE;
            rem_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            rem_r <= rem_r - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          rem_r   <= {CNT_W{1'b0}};
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

  shift_stage_chain #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_chain (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_en    (shift_en_s),
    .recirc      (recirc_s),
    .clear       (clear_s),
    .din         (cmd_data),
    .stage_data  (stage_data),
    .stage_valid (stage_valid),
    .tap_out     (tap_out)
  );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed table-driven bench for shift_seq_ctrl plus hand-written sequences
// for the hold-while-busy and mid-rotate reset cases.
module tb_shift_seq_ctrl;

  localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1, ROT = 2'd2, CLR = 2'd3;
  localparam int NV = 28;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [3:0]   cmd_len;
  logic [15:0]  cmd_data;
  logic         busy;
  logic         done;
  logic [15:0]  tap_out;
  logic [127:0] stage_data;
  logic [7:0]   stage_valid;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  len;
    logic [15:0] data;
    logic [15:0] exp_s0;
    logic [15:0] exp_tap;
    logic [7:0]  exp_valid;
    int          exp_lat;
  } vec_t;

  vec_t vecs [NV];
  int   checks = 0;
  int   errors = 0;

  shift_seq_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .cmd_data    (cmd_data),
    .busy        (busy),
    .done        (done),
    .tap_out     (tap_out),
    .stage_data  (stage_data),
    .stage_valid (stage_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Issue a command, wait for acceptance, then measure edges until done and busy cycles.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] len, input logic [15:0] data,
                         output int lat, output int busy_n);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_data = data;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      errors++; checks++;
      $display("FAIL accept_timeout: cmd_ready stayed %0b, want 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    check("done_falls", {127'd0, done}, 128'd0);
    check("ready_back", {127'd0, cmd_ready}, 128'd1);
  endtask

  task automatic apply(input int i);
    int lat, bn, exp_busy;
    run_cmd(vecs[i].op, vecs[i].len, vecs[i].data, lat, bn);
    exp_busy = (vecs[i].op == ROT) ? vecs[i].exp_lat : 0;
    check($sformatf("v%0d_done_lat", i), 128'(lat), 128'(vecs[i].exp_lat));
    check($sformatf("v%0d_busy_cyc", i), 128'(bn), 128'(exp_busy));
    check($sformatf("v%0d_stage0", i), {112'd0, stage_data[15:0]}, {112'd0, vecs[i].exp_s0});
    check($sformatf("v%0d_tap", i), {112'd0, tap_out}, {112'd0, vecs[i].exp_tap});
    check($sformatf("v%0d_valid", i), {120'd0, stage_valid}, {120'd0, vecs[i].exp_valid});
  endtask

  initial begin
    int dones, edges;
    bit acc, r;

    // Scenario 2: walk a single 1 to the tap end.
    vecs[0] = '{PUSH, 4'd0, 16'h0001, 16'h0001, 16'h0000, 8'h01, 0};
    for (int i = 1; i < 8; i++)
      vecs[i] = '{PUSH, 4'd0, 16'h0000, 16'h0000, (i == 7) ? 16'h0001 : 16'h0000,
                  8'((16'd1 << (i + 1)) - 16'd1), 0};
    // Scenario 3: fill with A1..A8 (stage k = A(8-k)), then rotate.
    for (int i = 0; i < 8; i++)
      vecs[8 + i] = '{PUSH, 4'd0, 16'h00A1 + 16'(i), 16'h00A1 + 16'(i),
                      (i == 7) ? 16'h00A1 : 16'h0000, 8'hFF, 0};
    vecs[16] = '{ROT, 4'd3,  16'h0000, 16'h00A3, 16'h00A4, 8'hFF, 3};
    vecs[17] = '{ROT, 4'd8,  16'h0000, 16'h00A3, 16'h00A4, 8'hFF, 8};
    vecs[18] = '{ROT, 4'd0,  16'h0000, 16'h00A3, 16'h00A4, 8'hFF, 0};
    vecs[19] = '{NOP, 4'd5,  16'h1234, 16'h00A3, 16'h00A4, 8'hFF, 0};
    vecs[20] = '{ROT, 4'd11, 16'h0000, 16'h00A6, 16'h00A7, 8'hFF, 11};
    vecs[21] = '{ROT, 4'd2,  16'h0000, 16'h00A8, 16'h00A1, 8'hFF, 2};
    // Scenario 6 tail: five pushes after the reset, then CLEAR.
    for (int i = 0; i < 5; i++)
      vecs[22 + i] = '{PUSH, 4'd0, 16'h00B1 + 16'(i), 16'h00B1 + 16'(i), 16'h0000,
                       8'((16'd1 << (i + 1)) - 16'd1), 0};
    vecs[27] = '{CLR, 4'd0, 16'hDEAD, 16'h0000, 16'h0000, 8'h00, 0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 4'd0; cmd_data = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_stage_data", stage_data, 128'd0);
    check("rst_valid", {120'd0, stage_valid}, 128'd0);
    check("rst_ready", {127'd0, cmd_ready}, 128'd1);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_done", {127'd0, done}, 128'd0);

    for (int i = 0; i < 22; i++) begin
      apply(i);
      if (i == 7) check("walk_full", stage_data, {16'h0001, 112'd0});
      if (i == 16) check("rot3_full", stage_data,
                         {16'h00A4, 16'h00A5, 16'h00A6, 16'h00A7, 16'h00A8, 16'h00A1, 16'h00A2, 16'h00A3});
    end

    // Scenario 5: ROTATE 4, then hold a PUSH 0xFFFF while the block is busy.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ROT; cmd_len = 4'd4; cmd_data = 16'h0000;
    @(posedge clk); #1;
    cmd_op = PUSH; cmd_data = 16'hFFFF;
    edges = 0; dones = 0; acc = 1'b0;
    while (!acc && edges < 20) begin
      @(negedge clk);
      r = cmd_ready;
      if (done) dones++;
      @(posedge clk);
      edges++;
      if (r) acc = 1'b1;
    end
    #1 cmd_valid = 1'b0;
    check("hold_accept_edge", 128'(edges), 128'd6);
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("hold_done_count", 128'(dones), 128'd2);
    check("hold_stage0", {112'd0, stage_data[15:0]}, {112'd0, 16'hFFFF});
    check("hold_stage1", {112'd0, stage_data[31:16]}, {112'd0, 16'h00A4});
    check("hold_tap", {112'd0, tap_out}, {112'd0, 16'h00A6});
    check("hold_valid", {120'd0, stage_valid}, 128'hFF);

    // Scenario 6: reset in the middle of a 10-step rotate.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ROT; cmd_len = 4'd10;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_stage_data", stage_data, 128'd0);
    check("abort_valid", {120'd0, stage_valid}, 128'd0);
    check("abort_busy", {127'd0, busy}, 128'd0);
    check("abort_ready", {127'd0, cmd_ready}, 128'd1);
    dones = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 128'(dones), 128'd0);

    for (int i = 22; i < NV; i++) apply(i);
    check("clear_stage_data", stage_data, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
